// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM 5-stage pipeline control: tracked-writer record,
// forwarding encoding and select-width helper.
package arm_pipe_pkg;

    // Widest register address a tracked entry can hold; narrower REG_AW is zero-extended.
    localparam int DEST_MAX_W = 8;
    localparam int FWD_RF     = 0;

    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  mem_r;
        logic                  mem_w;
        logic [DEST_MAX_W-1:0] dest;
    } trk_entry_t;

    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_trk_slot.sv
// One tracked-writer slot: holds during a memory stall, otherwise clears or
// loads the entry from the previous stage.
module pipe_trk_slot
    import arm_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       clr,
    input  trk_entry_t d,
    output trk_entry_t q
);

    // NOTE: slots are reset, not left to power-up; a random valid bit would
    // raise hazards and forwarding against instructions that never existed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (!hold) begin
            // NOTE: non-blocking, so each slot takes its neighbour's pre-edge
            // value and the whole chain shifts by exactly one stage per edge.
            if (clr) q <= '0;
            else     q <= d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage core: writer tracking, load-use/RAW hazards,
// forwarding selects, branch flush stretching, memory-wait stall, perf counters.
module pipe_hazard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter  int REG_AW    = 4,
    parameter  int DEPTH     = 2,
    parameter  int FWD_EN    = 1,
    parameter  int MEM_WAIT  = 0,
    parameter  int FLUSH_CYC = 1,
    parameter  int CNT_W     = 16,
    localparam int SELW      = sel_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              branch_taken,
    output logic              freeze,
    output logic              bubble,
    output logic              stall_all,
    output logic              flush,
    output logic [SELW-1:0]   fwd_sel1,
    output logic [SELW-1:0]   fwd_sel2,
    output logic [CNT_W-1:0]  perf_stall,
    output logic [CNT_W-1:0]  perf_flush
);

    localparam int               MC_W    = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam int               FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    trk_entry_t       slot_q [DEPTH];
    trk_entry_t       slot_d [DEPTH];
    logic [DEPTH-1:0] m1;
    logic [DEPTH-1:0] m2;
    logic             hazard;
    logic             ins_ok;
    logic             branch_ok;
    logic [MC_W-1:0]  mem_cnt;
    logic [FC_W-1:0]  flush_cnt;
    logic             unused_tail;

    function automatic logic match(input trk_entry_t e, input logic [REG_AW-1:0] r);
        return e.valid & e.wb_en & (e.dest == DEST_MAX_W'(r));
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            m1[i] = match(slot_q[i], id_src1);
            m2[i] = id_two_src & match(slot_q[i], id_src2);
        end
    end

    // With forwarding only a load still in EXE cannot be bypassed.
    always_comb begin
        if (FWD_EN != 0) hazard = slot_q[0].mem_r & (m1[0] | m2[0]);
        else             hazard = |(m1 | m2);
        hazard = hazard & id_valid;
    end

    // NOTE: defaults first so every path assigns both selects; no latch is inferred.
    always_comb begin
        fwd_sel1 = SELW'(FWD_RF);
        fwd_sel2 = SELW'(FWD_RF);
        if (FWD_EN != 0) begin
            // Scan oldest to youngest so the youngest matching writer wins.
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (!(i == 0 && slot_q[0].mem_r)) begin
                    if (m1[i]) fwd_sel1 = SELW'(i + 1);
                    if (m2[i]) fwd_sel2 = SELW'(i + 1);
                end
            end
        end
    end

    assign stall_all = (mem_cnt != '0);
    // Reset gates the live branch input so every output is quiet while held in reset.
    assign branch_ok = rst & branch_taken & !stall_all;
    assign flush     = branch_ok | (flush_cnt != '0);
    assign freeze    = hazard | stall_all | flush;
    assign bubble    = hazard & !stall_all & !flush;
    assign ins_ok    = id_valid & !hazard & !flush;

    assign slot_d[0] = '{valid: 1'b1, wb_en: id_wb_en, mem_r: id_mem_r_en,
                         mem_w: id_mem_w_en, dest: DEST_MAX_W'(id_dest)};

    for (genvar i = 1; i < DEPTH; i++) begin : g_chain
        assign slot_d[i] = slot_q[i-1];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        pipe_trk_slot u_slot (
            .clk  (clk),
            .rst  (rst),
            .hold (stall_all),
            .clr  ((i == 0) ? !ins_ok : 1'b0),
            .d    (slot_d[i]),
            .q    (slot_q[i])
        );
    end

    assign unused_tail = ^{slot_q[DEPTH-1].mem_r, slot_q[DEPTH-1].mem_w};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_cnt <= '0;
        end else if (!stall_all && (MEM_WAIT > 0) && slot_q[0].valid
                     && (slot_q[0].mem_r || slot_q[0].mem_w)) begin
            mem_cnt <= MC_W'(MEM_WAIT);
        end else if (mem_cnt != '0) begin
            mem_cnt <= mem_cnt - MC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt <= '0;
        end else if (branch_ok) begin
            flush_cnt <= FC_W'(FLUSH_CYC - 1);
        end else if (flush_cnt != '0 && !stall_all) begin
            flush_cnt <= flush_cnt - FC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (freeze && perf_stall != CNT_MAX)    perf_stall <= perf_stall + CNT_W'(1);
            if (branch_ok && perf_flush != CNT_MAX) perf_flush <= perf_flush + CNT_W'(1);
        end
    end

endmodule
